// File: rtl/dp_pkg.sv
// Shared constants for the 4-bit micro datapath: control-word bit positions,
// ALU opcodes and default sizes.
package dp_pkg;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_RAM_DEPTH = 16;

  // Control-word bit positions; bit 0 is reserved and ignored.
  localparam int CW_LA       = 15;
  localparam int CW_EA       = 14;
  localparam int CW_LB       = 13;
  localparam int CW_EU       = 12;
  localparam int CW_ALUOP_HI = 11;
  localparam int CW_ALUOP_LO = 9;
  localparam int CW_LO       = 8;
  localparam int CW_LF       = 7;
  localparam int CW_EI       = 6;
  localparam int CW_LM       = 5;
  localparam int CW_WR       = 4;
  localparam int CW_ER       = 3;
  localparam int CW_CLR      = 2;
  localparam int CW_HLT      = 1;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_INC = 3'b110,
    ALU_DEC = 3'b111
  } alu_op_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational 8-operation ALU on the A and B registers; carry doubles as
// borrow for SUB and as wrap indicator for INC/DEC.
module dp_alu
  import dp_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] result,
  output logic         carry
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_INC: begin
        result = a + W'(1);
        carry  = &a;
      end
      ALU_DEC: begin
        result = a - W'(1);
        carry  = ~|a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_datapath.sv
// Bus-oriented 4-bit datapath executing one control word per clock.
// Scratch RAM and MAR exist only when DP_SCRATCH_RAM_EN is defined.
module micro_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       control,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_ovf,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              bus_err
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_data_q, out_data_d;
  logic              z_q, z_d, c_q, c_d;
  logic              out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic              halted_q, halted_d, bus_err_q, bus_err_d;

  logic [15:0]       cw;
  logic [DATA_W-1:0] bus, alu_res, ram_rd;
  logic              alu_c;
  logic [2:0]        n_drivers;

  // Halting is implemented by masking the whole control word.
  assign cw = halted_q ? '0 : control;

  dp_alu #(.W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (alu_op_e'(cw[CW_ALUOP_HI:CW_ALUOP_LO])),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_comb begin
    bus = '0;
    if      (cw[CW_EU]) bus = alu_res;
    else if (cw[CW_EA]) bus = a_q;
    else if (cw[CW_ER]) bus = ram_rd;
    else if (cw[CW_EI]) bus = data_in;
  end

  assign n_drivers = 3'(cw[CW_EU]) + 3'(cw[CW_EA]) + 3'(cw[CW_ER]) + 3'(cw[CW_EI]);

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    halted_d    = halted_q | cw[CW_HLT];
    bus_err_d   = bus_err_q | (n_drivers > 3'd1);

    if (cw[CW_CLR])     a_d = '0;
    else if (cw[CW_LA]) a_d = bus;
    if (cw[CW_LB])      b_d = bus;

    if (cw[CW_LF]) begin
      z_d = (alu_res == '0);
      c_d = alu_c;
    end

    // A load into a still-full, unaccepted register is an overrun.
    if (cw[CW_LO]) begin
      out_data_d  = bus;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) out_ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      halted_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      halted_q    <= halted_d;
      bus_err_q   <= bus_err_d;
    end
  end

`ifdef DP_SCRATCH_RAM_EN
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic              unused_cw;

  assign ram_rd    = ram_q[mar_q];
  assign unused_cw = control[0];

  // NOTE: the RAM is built from flops so it can honour the full reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mar_q <= '0;
      ram_q <= '{default: '0};
    end else begin
      if (cw[CW_WR]) ram_q[mar_q] <= bus;
      if (cw[CW_LM]) mar_q        <= bus[ADDR_W-1:0];
    end
  end
`else
  logic unused_cw;

  assign ram_rd    = '0;
  assign unused_cw = ^{control[0], cw[CW_LM], cw[CW_WR]};
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign acc_out   = a_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = halted_q;
  assign bus_err   = bus_err_q;

endmodule
